// File: rtl/switch_pkg.sv
// Shared constants and types for the 2x2 switch scheduler slice.
package switch_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        DEST_OUT1 = 1'b0,
        DEST_OUT2 = 1'b1
    } dest_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/switch_2cross2.sv
// 2x2 payload crossbar: straight when io_sel is 0, swapped when 1.
module switch_2cross2
    import switch_pkg::*;
(
    input  logic              io_sel,
    input  logic [DATA_W-1:0] io_in1,
    input  logic [DATA_W-1:0] io_in2,
    output logic [DATA_W-1:0] io_out1,
    output logic [DATA_W-1:0] io_out2
);

    always_comb begin
        io_out1 = io_sel ? io_in2 : io_in1;
        io_out2 = io_sel ? io_in1 : io_in2;
    end

endmodule

// File: rtl/switch_2x2_sched.sv
// 2x2 switch with per-output registers, round-robin conflict arbitration
// and a saturating conflict counter.
module switch_2x2_sched
    import switch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in1_valid,
    input  logic              io_in2_valid,
    input  logic [DATA_W-1:0] io_in1_bits,
    input  logic [DATA_W-1:0] io_in2_bits,
    input  logic              io_in1_dest,
    input  logic              io_in2_dest,
    output logic              io_in1_ready,
    output logic              io_in2_ready,
    output logic              io_out1_valid,
    output logic              io_out2_valid,
    output logic [DATA_W-1:0] io_out1_bits,
    output logic [DATA_W-1:0] io_out2_bits,
    input  logic              io_out1_ready,
    input  logic              io_out2_ready,
    output logic              io_sel,
    output logic              io_prio,
    output logic [CNT_W-1:0]  io_conflicts
);

    logic              r_v1, r_v2, r_prio;
    logic [DATA_W-1:0] r_d1, r_d2;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_free1, w_free2, w_conflict, w_cfree;
    logic              w_g1, w_g2, w_sel, w_ld1, w_ld2;
    logic [DATA_W-1:0] w_x1, w_x2;

    always_comb begin
        w_free1    = !r_v1 || io_out1_ready;
        w_free2    = !r_v2 || io_out2_ready;
        w_conflict = io_in1_valid && io_in2_valid && (io_in1_dest == io_in2_dest);
        w_cfree    = (io_in1_dest == DEST_OUT2) ? w_free2 : w_free1;
        w_g1       = 1'b0;
        w_g2       = 1'b0;
        if (!reset) begin
            if (w_conflict) begin
                w_g1 = w_cfree && !r_prio;
                w_g2 = w_cfree && r_prio;
            end else begin
                w_g1 = io_in1_valid && ((io_in1_dest == DEST_OUT2) ? w_free2 : w_free1);
                w_g2 = io_in2_valid && ((io_in2_dest == DEST_OUT2) ? w_free2 : w_free1);
            end
        end
        // Only one input can target a port per cycle, so io_sel alone steers both loads.
        w_sel = (w_g1 && io_in1_dest == DEST_OUT2) || (w_g2 && io_in2_dest == DEST_OUT1);
        w_ld1 = (w_g1 && io_in1_dest == DEST_OUT1) || (w_g2 && io_in2_dest == DEST_OUT1);
        w_ld2 = (w_g1 && io_in1_dest == DEST_OUT2) || (w_g2 && io_in2_dest == DEST_OUT2);
    end

    switch_2cross2 u_xbar (
        .io_sel  (w_sel),
        .io_in1  (io_in1_bits),
        .io_in2  (io_in2_bits),
        .io_out1 (w_x1),
        .io_out2 (w_x2)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_d1   <= '0;
            r_d2   <= '0;
            r_prio <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_ld1) begin
                r_v1 <= 1'b1;
                r_d1 <= w_x1;
            end else if (io_out1_ready) begin
                r_v1 <= 1'b0;
            end
            if (w_ld2) begin
                r_v2 <= 1'b1;
                r_d2 <= w_x2;
            end else if (io_out2_ready) begin
                r_v2 <= 1'b0;
            end
            if (w_conflict && (w_g1 || w_g2)) begin
                r_prio <= ~r_prio;
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign io_in1_ready  = w_g1;
    assign io_in2_ready  = w_g2;
    assign io_sel        = w_sel;
    assign io_out1_valid = r_v1;
    assign io_out2_valid = r_v2;
    assign io_out1_bits  = r_d1;
    assign io_out2_bits  = r_d2;
    assign io_prio       = r_prio;
    assign io_conflicts  = r_cnt;

endmodule

// File: tb/tb_switch_2x2_sched.sv
// Self-checking bench for switch_2x2_sched: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_switch_2x2_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_in1_valid = 1'b0, io_in2_valid = 1'b0;
    logic [31:0] io_in1_bits = '0, io_in2_bits = '0;
    logic        io_in1_dest = 1'b0, io_in2_dest = 1'b0;
    logic        io_in1_ready, io_in2_ready;
    logic        io_out1_valid, io_out2_valid;
    logic [31:0] io_out1_bits, io_out2_bits;
    logic        io_out1_ready = 1'b0, io_out2_ready = 1'b0;
    logic        io_sel, io_prio;
    logic [7:0]  io_conflicts;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_v[2];
    logic [31:0] m_dat[2];
    logic        m_prio;
    int          m_cnt;
    logic        e_g[2];
    logic        e_sel;

    switch_2x2_sched dut (
        .clock         (clock),
        .reset         (reset),
        .io_in1_valid  (io_in1_valid),
        .io_in2_valid  (io_in2_valid),
        .io_in1_bits   (io_in1_bits),
        .io_in2_bits   (io_in2_bits),
        .io_in1_dest   (io_in1_dest),
        .io_in2_dest   (io_in2_dest),
        .io_in1_ready  (io_in1_ready),
        .io_in2_ready  (io_in2_ready),
        .io_out1_valid (io_out1_valid),
        .io_out2_valid (io_out2_valid),
        .io_out1_bits  (io_out1_bits),
        .io_out2_bits  (io_out2_bits),
        .io_out1_ready (io_out1_ready),
        .io_out2_ready (io_out2_ready),
        .io_sel        (io_sel),
        .io_prio       (io_prio),
        .io_conflicts  (io_conflicts)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic v1, input logic d1, input logic [31:0] b1,
                         input logic v2, input logic d2, input logic [31:0] b2,
                         input logic r1, input logic r2);
        io_in1_valid = v1; io_in1_dest = d1; io_in1_bits = b1;
        io_in2_valid = v2; io_in2_dest = d2; io_in2_bits = b2;
        io_out1_ready = r1; io_out2_ready = r2;
    endtask

    // Expected grants and crossbar setting from the current inputs and model state
    task automatic model_eval();
        logic v[2], d[2], fr[2];
        v[0] = io_in1_valid; v[1] = io_in2_valid;
        d[0] = io_in1_dest;  d[1] = io_in2_dest;
        fr[0] = !m_v[0] || io_out1_ready;
        fr[1] = !m_v[1] || io_out2_ready;
        e_g[0] = 1'b0; e_g[1] = 1'b0;
        if (!reset) begin
            if (v[0] && v[1] && d[0] == d[1]) begin
                if (fr[d[0]]) e_g[m_prio] = 1'b1;
            end else begin
                for (int i = 0; i < 2; i++)
                    if (v[i] && fr[d[i]]) e_g[i] = 1'b1;
            end
        end
        e_sel = 1'b0;
        for (int i = 0; i < 2; i++)
            if (e_g[i] && int'(d[i]) != i) e_sel = 1'b1;
    endtask

    task automatic model_commit();
        logic v[2], d[2], rdy[2];
        logic [31:0] b[2];
        v[0] = io_in1_valid; v[1] = io_in2_valid;
        d[0] = io_in1_dest;  d[1] = io_in2_dest;
        b[0] = io_in1_bits;  b[1] = io_in2_bits;
        rdy[0] = io_out1_ready; rdy[1] = io_out2_ready;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin m_v[k] = 1'b0; m_dat[k] = '0; end
            m_prio = 1'b0;
            m_cnt  = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic loaded = 1'b0;
                for (int i = 0; i < 2; i++)
                    if (e_g[i] && int'(d[i]) == k) begin loaded = 1'b1; m_dat[k] = b[i]; end
                if (loaded) m_v[k] = 1'b1;
                else if (rdy[k]) m_v[k] = 1'b0;
            end
            if (v[0] && v[1] && d[0] == d[1] && (e_g[0] || e_g[1])) begin
                m_prio = ~m_prio;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
            end
        end
    endtask

    // One clock: evaluate, advance model at the edge, return at the falling edge
    task automatic tick();
        model_eval();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 0, 32'h1, 1, 1, 32'h2, 1, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b0 || io_in2_ready !== 1'b0 || io_sel !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: ready1=%b ready2=%b sel=%b required 0 0 0", io_in1_ready, io_in2_ready, io_sel);
        end
        tick();
        checks++;
        if (io_out1_valid !== 1'b0 || io_out2_valid !== 1'b0 || io_prio !== 1'b0 || io_conflicts !== 8'd0 ||
            io_out1_bits !== 32'd0 || io_out2_bits !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: v1=%b v2=%b prio=%b cnt=%0d b1=%h b2=%h required all 0",
                     io_out1_valid, io_out2_valid, io_prio, io_conflicts, io_out1_bits, io_out2_bits);
        end
        reset = 1'b0;
    endtask

    task automatic test_straight();
        drive(1, 0, 32'hAAAA0001, 1, 1, 32'hBBBB0002, 1, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b1 || io_in2_ready !== 1'b1 || io_sel !== 1'b0) begin
            errors++;
            $display("FAIL straight_grant: ready1=%b ready2=%b sel=%b required 1 1 0", io_in1_ready, io_in2_ready, io_sel);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (io_out1_valid !== 1'b1 || io_out1_bits !== 32'hAAAA0001 || io_out2_valid !== 1'b1 || io_out2_bits !== 32'hBBBB0002) begin
            errors++;
            $display("FAIL straight_out: out1=%b/%h out2=%b/%h required 1/aaaa0001 1/bbbb0002",
                     io_out1_valid, io_out1_bits, io_out2_valid, io_out2_bits);
        end
    endtask

    task automatic test_crossed();
        drive(1, 1, 32'hC1C1C1C1, 1, 0, 32'hC2C2C2C2, 1, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b1 || io_in2_ready !== 1'b1 || io_sel !== 1'b1) begin
            errors++;
            $display("FAIL crossed_grant: ready1=%b ready2=%b sel=%b required 1 1 1", io_in1_ready, io_in2_ready, io_sel);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (io_out1_bits !== 32'hC2C2C2C2 || io_out2_bits !== 32'hC1C1C1C1 || io_out1_valid !== 1'b1 || io_out2_valid !== 1'b1) begin
            errors++;
            $display("FAIL crossed_out: out1=%b/%h out2=%b/%h required 1/c2c2c2c2 1/c1c1c1c1",
                     io_out1_valid, io_out1_bits, io_out2_valid, io_out2_bits);
        end
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            logic in2_wins = (c % 2 == 1);
            drive(1, 0, 32'h10000000 + c, 1, 0, 32'h20000000 + c, 1, 1);
            #1;
            checks++;
            if (io_in1_ready !== !in2_wins || io_in2_ready !== in2_wins || io_sel !== in2_wins) begin
                errors++;
                $display("FAIL rr_grant[%0d]: ready1=%b ready2=%b sel=%b required %b %b %b",
                         c, io_in1_ready, io_in2_ready, io_sel, !in2_wins, in2_wins, in2_wins);
            end
            tick();
            checks++;
            if (io_out1_bits !== (in2_wins ? 32'h20000000 + c : 32'h10000000 + c) || io_prio !== !in2_wins) begin
                errors++;
                $display("FAIL rr_out[%0d]: out1=%h prio=%b required %h %b", c, io_out1_bits, io_prio,
                         in2_wins ? 32'h20000000 + c : 32'h10000000 + c, !in2_wins);
            end
        end
        checks++;
        if (io_conflicts !== 8'd4) begin
            errors++;
            $display("FAIL rr_count: conflicts=%0d required 4", io_conflicts);
        end
    endtask

    task automatic test_backpressure();
        drive(1, 0, 32'hCCCC0001, 0, 0, 0, 0, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: ready1=%b required 0", io_in1_ready);
        end
        tick();
        checks++;
        if (io_out1_valid !== 1'b1 || io_out1_bits !== 32'h20000003 || io_prio !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: out1=%b/%h prio=%b required 1/20000003 0", io_out1_valid, io_out1_bits, io_prio);
        end
        drive(1, 0, 32'hCCCC0001, 1, 0, 32'hDDDD0001, 0, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b0 || io_in2_ready !== 1'b0 || io_sel !== 1'b0) begin
            errors++;
            $display("FAIL bp_conflict_ready: ready1=%b ready2=%b sel=%b required 0 0 0", io_in1_ready, io_in2_ready, io_sel);
        end
        tick();
        checks++;
        if (io_prio !== 1'b0 || io_conflicts !== 8'd4 || io_out1_bits !== 32'h20000003) begin
            errors++;
            $display("FAIL bp_conflict_state: prio=%b cnt=%0d out1=%h required 0 4 20000003", io_prio, io_conflicts, io_out1_bits);
        end
        drive(1, 0, 32'hCCCC0001, 0, 0, 0, 1, 1);
        #1;
        checks++;
        if (io_in1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: ready1=%b required 1", io_in1_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        checks++;
        if (io_out1_valid !== 1'b1 || io_out1_bits !== 32'hCCCC0001) begin
            errors++;
            $display("FAIL bp_release_out: out1=%b/%h required 1/cccc0001", io_out1_valid, io_out1_bits);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 300; c++) begin
            drive(1, 0, $urandom, 1, 0, $urandom, 1, 1);
            tick();
            if (c == 254) begin
                checks++;
                if (io_conflicts !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_reach: conflicts=%0d required 255", io_conflicts);
                end
            end
        end
        checks++;
        if (io_conflicts !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold: conflicts=%0d required 255", io_conflicts);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(39) == 0);
            drive($urandom_range(3) != 0, $urandom_range(1), $urandom,
                  $urandom_range(3) != 0, $urandom_range(1), $urandom,
                  $urandom_range(9) < 7, $urandom_range(9) < 7);
            #1;
            model_eval();
            checks++;
            if (io_in1_ready !== e_g[0] || io_in2_ready !== e_g[1] || io_sel !== e_sel) begin
                errors++;
                $display("FAIL rand_grant[%0d]: ready1=%b ready2=%b sel=%b required %b %b %b",
                         c, io_in1_ready, io_in2_ready, io_sel, e_g[0], e_g[1], e_sel);
            end
            tick();
            checks++;
            if (io_out1_valid !== m_v[0] || io_out2_valid !== m_v[1] || io_out1_bits !== m_dat[0] ||
                io_out2_bits !== m_dat[1] || io_prio !== m_prio || io_conflicts !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL rand_state[%0d]: v=%b%b b1=%h b2=%h prio=%b cnt=%0d required v=%b%b b1=%h b2=%h prio=%b cnt=%0d",
                         c, io_out1_valid, io_out2_valid, io_out1_bits, io_out2_bits, io_prio, io_conflicts,
                         m_v[0], m_v[1], m_dat[0], m_dat[1], m_prio, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_reset_midstream();
        drive(1, 0, 32'h55550001, 1, 0, 32'h55550002, 1, 1);
        tick();
        drive(1, 0, 32'h66660001, 1, 1, 32'h66660002, 1, 1);
        tick();
        drive(1, 0, 32'h77770001, 1, 1, 32'h77770002, 0, 0);
        reset = 1'b1;
        #1;
        checks++;
        if (io_out1_valid !== 1'b1 || io_out2_valid !== 1'b1 || io_in1_ready !== 1'b0 || io_in2_ready !== 1'b0 || io_sel !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_comb: v=%b%b ready1=%b ready2=%b sel=%b required v=11 0 0 0",
                     io_out1_valid, io_out2_valid, io_in1_ready, io_in2_ready, io_sel);
        end
        tick();
        checks++;
        if (io_out1_valid !== 1'b0 || io_out2_valid !== 1'b0 || io_prio !== 1'b0 || io_conflicts !== 8'd0 ||
            io_in1_ready !== 1'b0 || io_in2_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: v=%b%b prio=%b cnt=%0d ready1=%b ready2=%b required all 0",
                     io_out1_valid, io_out2_valid, io_prio, io_conflicts, io_in1_ready, io_in2_ready);
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_v[k] = 1'b0; m_dat[k] = '0; end
        m_prio = 1'b0;
        m_cnt  = 0;
        @(negedge clock);
        test_reset();
        test_straight();
        test_crossed();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/switch_2x2_sched.md
SWITCH_2X2_SCHED -- requirements
Module: switch_2x2_sched

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports io_in1_valid/io_in2_valid, input, 1 bit each: source offers a word.
REQ-004 SHALL have ports io_in1_bits/io_in2_bits, input, 32 bits each: payload.
REQ-005 SHALL have ports io_in1_dest/io_in2_dest, input, 1 bit each: 0 = out1, 1 = out2.
REQ-006 SHALL have ports io_in1_ready/io_in2_ready, output, 1 bit each: word accepted this cycle.
REQ-007 SHALL have ports io_out1_valid/io_out2_valid, output, 1 bit each: output register holds a word.
REQ-008 SHALL have ports io_out1_bits/io_out2_bits, output, 32 bits each: output register payload.
REQ-009 SHALL have ports io_out1_ready/io_out2_ready, input, 1 bit each: sink takes the word.
REQ-010 SHALL have port io_sel, output, 1 bit: crossbar setting this cycle; 0 = straight, 1 = crossed.
REQ-011 SHALL have port io_prio, output, 1 bit: round-robin pointer; 0 = in1 wins next conflict.
REQ-012 SHALL have port io_conflicts, output, 8 bits: saturating conflict count.

Function
REQ-013 SHALL hold one output register per output port, with a valid flag and 32-bit data.
REQ-014 SHALL treat output port k as free when its valid flag is 0 or io_outk_ready is 1.
REQ-015 SHALL define a conflict as both inputs valid with equal dest.
REQ-016 SHALL, with no conflict, grant each valid input whose destination port is free.
REQ-017 SHALL, on a conflict with the destination port free, grant only the input selected by io_prio.
REQ-018 SHALL, on a conflict with the destination port not free, grant neither input and leave io_prio unchanged.
REQ-019 SHALL drive io_ini_ready equal to the grant of input i; ready may depend combinationally on valid, dest and out ready.
REQ-020 SHALL drive io_sel = 1 when in1 is granted to out2 or in2 is granted to out1, and 0 otherwise, including when nothing is granted.
REQ-021 SHALL load a granted word into its destination output register at the next edge, giving 1-cycle latency and up to 2 words per cycle.
REQ-022 SHALL clear an output valid flag when the sink takes the word and no new grant targets that port; a take plus a new grant in the same cycle SHALL keep valid at 1 and load the new data.
REQ-023 SHALL toggle io_prio after any conflict cycle in which a grant occurs.
REQ-024 SHALL increment io_conflicts in that same conflict-with-grant cycle, saturating at 255 with no wrap.
REQ-025 SHALL hold output bits stable while valid is 1 and ready is 0.

Reset
REQ-026 SHALL, while reset is high, clear both output valid flags, output data, io_prio and io_conflicts to 0 at the clock edge.
REQ-027 SHALL force io_in1_ready, io_in2_ready and io_sel to 0 combinationally during reset.
REQ-028 SHALL discard in-flight words on reset mid-operation; no partial transfer is retained.

Structure
REQ-029 SHALL place the width constant (32), the dest encoding and the counter width (8) in shared package switch_pkg.
REQ-030 SHALL instantiate the existing switch_2cross2 as its single sub-module for payload routing, driven by io_sel.
REQ-031 SHALL keep grant logic, output registers and priority/counter state in switch_2x2_sched.

Verification
REQ-032 SHALL test straight routing: in1 (dest 0, 0xAAAA0001) and in2 (dest 1, 0xBBBB0002) with both outs ready -> both readys 1, io_sel 0, next cycle out1 = 0xAAAA0001 and out2 = 0xBBBB0002.
REQ-033 SHALL test crossed routing: in1 dest 1, in2 dest 0 -> io_sel 1, both accepted, bits swapped at the outputs.
REQ-034 SHALL test round-robin: both inputs dest 0 for 4 cycles from reset -> grants in1, in2, in1, in2; io_prio toggles each cycle; io_conflicts = 4.
REQ-035 SHALL test backpressure: out1 valid with io_out1_ready 0, in1 dest 0 -> in1 ready 0, out1 bits unchanged, io_prio unchanged; after io_out1_ready goes 1 -> in1 accepted the same cycle.
REQ-036 SHALL test saturation: 300 conflict-with-grant cycles -> io_conflicts = 255.
REQ-037 SHALL test reset mid-stream: reset asserted with both outputs valid -> next cycle both valids 0, io_prio 0, io_conflicts 0, readys 0 while reset is high.
